key_debounce: RTL and testbench
===============================

KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 Parameter N_KEYS, default 4, number of independent pushbutton channels.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000, consecutive stable cycles required to accept a level (20 ms at 50 MHz); legal range 2..2^24.
REQ-003 clk  input  1  system clock, 50 MHz (CLOCK_50 domain).
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 key_n  input  N_KEYS  raw pushbutton levels, active-low, asynchronous to clk.
REQ-006 pressed  output  N_KEYS  debounced level, active-high; drives the system buttons PIO export directly.
REQ-007 press_pulse  output  N_KEYS  one-cycle strobe per channel on accepted press.
REQ-008 release_pulse  output  N_KEYS  one-cycle strobe per channel on accepted release.
REQ-009 any_pressed  output  1  OR-reduction of pressed.

Function
REQ-010 Each key_n bit SHALL pass through a 2-flop synchronizer; the synchronized value is inverted to form the active-high sample s.
REQ-011 Each channel SHALL hold a counter of width clog2(DEBOUNCE_CYCLES); the counter clears on any cycle where s equals pressed.
REQ-012 While s differs from pressed, the counter SHALL increment by 1 per cycle.
REQ-013 On a cycle where s differs from pressed and the counter equals DEBOUNCE_CYCLES-1, pressed SHALL toggle at that clock edge and the counter SHALL clear.
REQ-014 Any return of s to the pressed value before the threshold (glitch/bounce) SHALL clear the counter with no output change.
REQ-015 Latency: a clean level change on key_n, first sampled at edge k, SHALL appear on pressed at edge k+1+DEBOUNCE_CYCLES.
REQ-016 press_pulse[i] SHALL be high for exactly the one cycle in which pressed[i] first reads 1; release_pulse[i] likewise for the first cycle pressed[i] reads 0; pulses SHALL be registered, aligned with pressed, never both high.
REQ-017 Counter SHALL never wrap; reaching the threshold always toggles and clears.
REQ-018 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL produce simultaneous pulses.
REQ-019 any_pressed SHALL be combinational from registered pressed (no extra latency).

Reset
REQ-020 While reset is high: synchronizer flops = 1 (released), counters = 0, pressed = 0, press_pulse = 0, release_pulse = 0.
REQ-021 Reset asserted mid-count SHALL discard the count; a key held through reset SHALL produce a press only after a full DEBOUNCE_CYCLES after reset deasserts, plus synchronizer latency.
REQ-022 No output pulse SHALL be generated by reset assertion or deassertion itself.

Structure
REQ-023 Shared package/header key_debounce_pkg SHALL hold N_KEYS default, DEBOUNCE_CYCLES default, and CLK_HZ = 50000000 with the ms-to-cycles conversion constant.
REQ-024 One sub-module debounce_channel (synchronizer, counter, level, pulse logic for one bit) SHALL be instantiated N_KEYS times via generate; the top adds only any_pressed.
REQ-025 The top-level design SHALL connect pressed to buttons_0_export in place of the direct ~KEY inversion.

Verification (DEBOUNCE_CYCLES = 8)
REQ-026 Clean press: key_n[0] 1->0 at edge k, held -> pressed[0]=1 and press_pulse[0]=1 at edge k+9, press_pulse[0]=0 at k+10.
REQ-027 Bounce: key_n[1] toggles low 5 cycles, high 2, low held -> single press_pulse[1] 9 edges after the final falling sample, no earlier output change.
REQ-028 Release: key_n[0] 0->1 after accepted press -> pressed[0]=0 with one-cycle release_pulse[0] 9 edges later; press_pulse stays 0.
REQ-029 Simultaneous: key_n 4'b1111->4'b0000 at one edge -> all four press_pulse bits high in the same cycle, any_pressed=1 same cycle.
REQ-030 Reset mid-count: key_n[2] low, reset pulsed after 5 cycles -> no pulse; press_pulse[2] appears 10 edges after reset deasserts (2 sync + 8), pressed=0 throughout reset.
REQ-031 Glitch rejection: 7-cycle low pulse on key_n[3] -> pressed[3] stays 0, no pulses.

Source files
------------

// File: rtl/key_debounce_pkg.sv
// Shared constants for the pushbutton debouncer: channel count, clock rate,
// and the millisecond-to-cycle conversion used to size the debounce window.
package key_debounce_pkg;

  localparam int unsigned N_KEYS_DEF          = 4;
  localparam int unsigned CLK_HZ              = 50_000_000;
  localparam int unsigned CYCLES_PER_MS       = CLK_HZ / 1000;
  localparam int unsigned DEBOUNCE_MS_DEF     = 20;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = DEBOUNCE_MS_DEF * CYCLES_PER_MS;

  function automatic int unsigned ms_to_cycles(input int unsigned ms);
    return ms * CYCLES_PER_MS;
  endfunction

  // Counter width for a window of `cycles`; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/key_debounce_if.sv
// Pushbutton bundle: raw active-low keys in, debounced levels and strobes out.
// press_pulse/release_pulse are single-cycle strobes with no back-pressure;
// they are registered and aligned with the cycle in which pressed changes.
interface key_debounce_if
  import key_debounce_pkg::*;
#(
  parameter int unsigned N_KEYS = N_KEYS_DEF
) ();

  logic [N_KEYS-1:0] key_n;
  logic [N_KEYS-1:0] pressed;
  logic [N_KEYS-1:0] press_pulse;
  logic [N_KEYS-1:0] release_pulse;
  logic              any_pressed;

  modport master (
    input  key_n,
    output pressed,
    output press_pulse,
    output release_pulse,
    output any_pressed
  );

  modport slave (
    output key_n,
    input  pressed,
    input  press_pulse,
    input  release_pulse,
    input  any_pressed
  );

endinterface

// File: rtl/key_debounce_channel.sv
// One debounced pushbutton: 2-flop synchronizer, stability counter, accepted
// level and registered press/release strobes.
module debounce_channel
  import key_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic             s;
  logic             differ;
  logic             accept;

  // Synchronizer idles at 1 (released) so reset never looks like a press.
  assign s      = ~sync_q[1];
  assign differ = s ^ pressed;
  assign accept = differ && (cnt_q == CNT_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q        <= 2'b11;
      cnt_q         <= '0;
      pressed       <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      sync_q        <= {sync_q[0], key_n};
      press_pulse   <= accept & ~pressed;
      release_pulse <= accept & pressed;
      if (!differ || accept) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (accept) begin
        pressed <= ~pressed;
      end
    end
  end

endmodule

// File: rtl/key_debounce.sv
// Debounces N_KEYS independent pushbuttons; pressed feeds the buttons PIO
// export directly in the system top.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int unsigned N_KEYS          = N_KEYS_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  key_debounce_if.master bus
);

  logic [N_KEYS-1:0] pressed;
  logic [N_KEYS-1:0] press_pulse;
  logic [N_KEYS-1:0] release_pulse;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .key_n        (bus.key_n[i]),
      .pressed      (pressed[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i])
    );
  end

  assign bus.pressed       = pressed;
  assign bus.press_pulse   = press_pulse;
  assign bus.release_pulse = release_pulse;
  assign bus.any_pressed   = |pressed;

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce with a short debounce window: directed timing
// scenarios plus randomized key activity against a history-based model.
module tb_key_debounce;

  localparam int unsigned N = 4;
  localparam int unsigned D = 8;
  localparam int unsigned VW = 3 * N + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  key_debounce_if #(.N_KEYS(N)) bus ();

  key_debounce #(
    .N_KEYS         (N),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // A key level is accepted once the synchronized sample has disagreed with
  // the accepted level on each of the last D edges since the previous decision.
  logic [N-1:0] samp_q[$];
  bit           obs[N][$];
  logic [N-1:0] m_pressed = '0;
  logic [N-1:0] m_pp = '0;
  logic [N-1:0] m_rp = '0;
  logic [N-1:0] m_s;
  bit           all_diff;

  always @(posedge clk) begin
    m_pp = '0;
    m_rp = '0;
    if (reset) begin
      samp_q.delete();
      samp_q.push_back('1);
      samp_q.push_back('1);
      m_pressed = '0;
      for (int i = 0; i < N; i++) obs[i].delete();
    end else begin
      m_s = ~samp_q[0];
      samp_q.push_back(bus.key_n);
      void'(samp_q.pop_front());
      for (int i = 0; i < N; i++) begin
        obs[i].push_back(m_s[i]);
        if (obs[i].size() > D) void'(obs[i].pop_front());
        all_diff = (obs[i].size() == D);
        foreach (obs[i][k]) if (obs[i][k] == m_pressed[i]) all_diff = 0;
        if (all_diff) begin
          if (m_pressed[i]) m_rp[i] = 1'b1;
          else              m_pp[i] = 1'b1;
          m_pressed[i] = ~m_pressed[i];
          obs[i].delete();
        end
      end
    end
  end

  logic [VW-1:0] dut_vec;
  logic [VW-1:0] mdl_vec;
  assign dut_vec = {bus.pressed, bus.press_pulse, bus.release_pulse, bus.any_pressed};
  assign mdl_vec = {m_pressed, m_pp, m_rp, |m_pressed};

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== mdl_vec) begin
        errors++;
        $display("FAIL idle_model t=%0t got=%h exp=%h", $time, dut_vec, mdl_vec);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.key_n = N'($urandom);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== '0) begin
        errors++;
        $display("FAIL reset_state got=%h exp=0", dut_vec);
      end
    end
    bus.key_n = '1;
    reset = 1'b0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== '0) begin
        errors++;
        $display("FAIL reset_release_quiet got=%h exp=0", dut_vec);
      end
    end
  endtask

  // Key 0 goes low; edge k is the first posedge after this negedge.
  task automatic test_clean_press();
    @(negedge clk);
    bus.key_n[0] = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      checks++;
      if (bus.pressed[0] !== (j >= 10) || bus.press_pulse[0] !== (j == 10)
          || bus.release_pulse[0] !== 1'b0 || bus.any_pressed !== (j >= 10)) begin
        errors++;
        $display("FAIL clean_press edge=k+%0d got p=%b pp=%b rp=%b any=%b exp p=%b pp=%b",
                 j - 1, bus.pressed[0], bus.press_pulse[0], bus.release_pulse[0],
                 bus.any_pressed, (j >= 10), (j == 10));
      end
      checks++;
      if (dut_vec !== mdl_vec) begin
        errors++;
        $display("FAIL clean_press_model got=%h exp=%h", dut_vec, mdl_vec);
      end
    end
  endtask

  task automatic test_release();
    @(negedge clk);
    bus.key_n[0] = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      checks++;
      if (bus.pressed[0] !== (j < 10) || bus.release_pulse[0] !== (j == 10)
          || bus.press_pulse[0] !== 1'b0) begin
        errors++;
        $display("FAIL release edge=k+%0d got p=%b pp=%b rp=%b exp p=%b rp=%b",
                 j - 1, bus.pressed[0], bus.press_pulse[0], bus.release_pulse[0],
                 (j < 10), (j == 10));
      end
    end
  endtask

  task automatic test_bounce();
    @(negedge clk);
    bus.key_n[1] = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      checks++;
      if (bus.pressed[1] !== 1'b0 || bus.press_pulse[1] !== 1'b0) begin
        errors++;
        $display("FAIL bounce_early got p=%b pp=%b exp 0", bus.pressed[1], bus.press_pulse[1]);
      end
    end
    bus.key_n[1] = 1'b1;
    idle(2);
    bus.key_n[1] = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      checks++;
      if (bus.pressed[1] !== (j >= 10) || bus.press_pulse[1] !== (j == 10)) begin
        errors++;
        $display("FAIL bounce edge=k+%0d got p=%b pp=%b exp p=%b pp=%b",
                 j - 1, bus.pressed[1], bus.press_pulse[1], (j >= 10), (j == 10));
      end
    end
    bus.key_n[1] = 1'b1;
    idle(12);
  endtask

  task automatic test_simultaneous();
    @(negedge clk);
    bus.key_n = '0;
    for (int j = 1; j <= 11; j++) begin
      @(negedge clk);
      checks++;
      if (bus.press_pulse !== ((j == 10) ? 4'hF : 4'h0) || bus.any_pressed !== (j >= 10)) begin
        errors++;
        $display("FAIL simul_press edge=k+%0d got pp=%h any=%b", j - 1, bus.press_pulse,
                 bus.any_pressed);
      end
    end
    bus.key_n = '1;
    for (int j = 1; j <= 11; j++) begin
      @(negedge clk);
      checks++;
      if (bus.release_pulse !== ((j == 10) ? 4'hF : 4'h0) || bus.any_pressed !== (j < 10)) begin
        errors++;
        $display("FAIL simul_release edge=k+%0d got rp=%h any=%b", j - 1, bus.release_pulse,
                 bus.any_pressed);
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.key_n[2] = 1'b0;
    idle(5);
    reset = 1'b1;
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== '0) begin
        errors++;
        $display("FAIL reset_mid_hold got=%h exp=0", dut_vec);
      end
    end
    reset = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      checks++;
      if (bus.pressed[2] !== (j >= 10) || bus.press_pulse[2] !== (j == 10)
          || bus.release_pulse !== '0) begin
        errors++;
        $display("FAIL reset_mid edge=%0d got p=%b pp=%b rp=%h exp p=%b pp=%b", j,
                 bus.pressed[2], bus.press_pulse[2], bus.release_pulse, (j >= 10), (j == 10));
      end
    end
    bus.key_n[2] = 1'b1;
    idle(12);
  endtask

  task automatic test_glitch();
    @(negedge clk);
    bus.key_n[3] = 1'b0;
    repeat (7) @(negedge clk);
    bus.key_n[3] = 1'b1;
    for (int j = 0; j < 15; j++) begin
      @(negedge clk);
      checks++;
      if (bus.pressed[3] !== 1'b0 || bus.press_pulse[3] !== 1'b0 || bus.release_pulse[3] !== 1'b0) begin
        errors++;
        $display("FAIL glitch got p=%b pp=%b rp=%b exp 0", bus.pressed[3], bus.press_pulse[3],
                 bus.release_pulse[3]);
      end
    end
  endtask

  task automatic test_random();
    int hold;
    for (int seg = 0; seg < 60; seg++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 19) == 0);
      bus.key_n = N'($urandom);
      hold = $urandom_range(1, 12);
      for (int j = 0; j < hold; j++) begin
        if (j == 1) reset = 1'b0;
        @(negedge clk);
        checks++;
        if (dut_vec !== mdl_vec) begin
          errors++;
          $display("FAIL random seg=%0d got=%h exp=%h", seg, dut_vec, mdl_vec);
        end
      end
      reset = 1'b0;
    end
    bus.key_n = '1;
    idle(12);
  endtask

  initial begin
    bus.key_n = '1;
    repeat (3) @(negedge clk);
    test_reset();
    test_clean_press();
    test_release();
    test_bounce();
    test_simultaneous();
    test_reset_mid();
    test_glitch();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
